add_sub_iter: RTL and testbench

- Parametrised, multi-cycle integer add/subtract unit with full flag generation (Z, V, N, C) for signed and unsigned modes.
- Processes CHUNK bits per clock, ripple-carrying between chunks through a registered carry. This trades latency for a short critical path.
- Sits between the ALU operand muxes and the ALU result/flag register. It uses valid/ready handshakes on both sides so the pipeline control can stall it.

---
 rtl/add_sub_pkg.sv | 27 ++
 rtl/add_chunk.sv | 22 ++
 rtl/add_sub_iter.sv | 161 ++++++++++++++++
 tb/tb_add_sub_iter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and elaboration helpers for the iterative add/subtract unit.
// Holds the control-state encoding, the flag bundle and the chunk-count math.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic c;
  } flags_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice with carry-out and carry-into-MSB.
// The carry into the top bit drives the signed overflow check on the final slice.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out by xor.
  assign cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/add_sub_iter.sv
// Multi-cycle add/subtract: CHUNK bits per clock through one shared adder slice,
// with a registered ripple carry and Z/V/N/C flags generated on the final slice.
module add_sub_iter
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c,
  output logic             busy
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("add_sub_iter: WIDTH must be a multiple of CHUNK");
  end

  state_e              state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                carry_q;
  logic                sign_q;
  logic                sub_q;
  logic [IDX_W-1:0]    idx_q;
  logic                zacc_q;
  logic [WIDTH-1:0]    s_q;
  flags_t              flags_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  int                  chunk_base;
  logic [CHUNK-1:0]    chunk_a;
  logic [CHUNK-1:0]    chunk_b;
  logic [CHUNK-1:0]    chunk_sum;
  logic                chunk_cout;
  logic                chunk_cmsb;

  logic [WIDTH-1:0]    s_d;
  logic                zacc_d;
  flags_t              flags_d;
  logic                is_last;

  assign chunk_base = int'(idx_q) * CHUNK;
  assign chunk_a    = a_q[chunk_base +: CHUNK];
  assign chunk_b    = b_q[chunk_base +: CHUNK];
  assign is_last    = (idx_q == LAST_IDX);

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  always_comb begin
    // NOTE: every output of this block gets a default before any conditional
    // update; leaving a path unassigned would infer a latch.
    s_d                      = s_q;
    s_d[chunk_base +: CHUNK] = chunk_sum;
    zacc_d                   = zacc_q & (chunk_sum == '0);
    flags_d.c                = chunk_cout;
    flags_d.v                = sign_q ? (chunk_cmsb ^ chunk_cout) : (chunk_cout ^ sub_q);
    flags_d.n                = sign_q & (chunk_sum[CHUNK-1] ^ flags_d.v);
    flags_d.z                = zacc_d;
  end

  // NOTE: all state below uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      zacc_q      <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            // Subtraction is A + ~B + 1: invert B here, seed the carry with sub.
            b_q        <= b ^ {WIDTH{sub}};
            carry_q    <= sub;
            sign_q     <= sign;
            sub_q      <= sub;
            idx_q      <= '0;
            zacc_q     <= 1'b1;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= chunk_cout;
          zacc_q  <= zacc_d;
          if (is_last) begin
            flags_q     <= flags_d;
            idx_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign s         = s_q;
  assign z         = flags_q.z;
  assign v         = flags_q.v;
  assign n         = flags_q.n;
  assign c         = flags_q.c;

endmodule

// File: tb/tb_add_sub_iter.sv
// Self-checking bench for add_sub_iter: directed corner cases, randomized traffic
// against an arithmetic reference model, stall, reset and single-chunk configs.
module tb_add_sub_iter;

  localparam int W   = 32;
  localparam int CK  = 4;
  localparam int NCH = W / CK;

  typedef struct packed {
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;
    logic        c;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sign;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, sub, sign, out_valid, out_ready;
  logic          z, v, n, c, busy;
  logic [W-1:0]  a, b, s;

  logic          in_valid8, in_ready8, sub8, sign8, out_valid8, out_ready8;
  logic          z8, v8, n8, c8, busy8;
  logic [7:0]    a8, b8, s8;

  int checks = 0;
  int errors = 0;

  add_sub_iter #(.WIDTH(W), .CHUNK(CK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sign(sign), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .z(z), .v(v), .n(n), .c(c), .busy(busy)
  );

  add_sub_iter #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .sign(sign8), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .z(z8), .v(v8), .n(n8), .c(c8), .busy(busy8)
  );

  // Reference: plain integer arithmetic on the mathematical operands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic do_sub, input logic do_sign);
    res_t        r;
    logic [32:0] wide;
    longint      sx, sy, sr;
    longint      max_pos = 64'sd2147483647;
    longint      min_neg = -64'sd2147483648;
    wide = {1'b0, x} + {1'b0, y};
    r.s  = do_sub ? x - y : x + y;
    r.c  = do_sub ? (x >= y) : wide[32];
    if (do_sign) begin
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      sr  = do_sub ? sx - sy : sx + sy;
      r.v = (sr > max_pos) || (sr < min_neg);
      r.n = (sr < 0);
    end else begin
      r.v = do_sub ? (x < y) : wide[32];
      r.n = 1'b0;
    end
    r.z = (r.s == 32'd0);
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r = {s, z, v, n, c};
    return r;
  endfunction

  // Issue one operation, scramble the inputs after acceptance, wait for the
  // result, then complete the output handshake.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tsub, input logic tsign,
                        output res_t r, output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
    end
    a = ta; b = tb_v; sub = tsub; sign = tsign; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = ~tsub; sign = ~tsign;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = observed();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_data: s/flags=%h required 0", observed());
    end
    checks++;
    if ({in_ready8, out_valid8, busy8, s8, z8, v8, n8, c8} !== {3'b100, 12'h000}) begin
      errors++;
      $display("FAIL reset_dut8: got %b", {in_ready8, out_valid8, busy8, s8, z8, v8, n8, c8});
    end
  endtask

  task automatic test_directed();
    vec_t vecs[7];
    res_t r;
    int   lat;
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1}};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1}};
    vecs[4] = '{32'h00000005, 32'h00000003, 1'b1, 1'b0, '{32'h00000002, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, '{32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sign, r, lat);
      checks++;
      if (r !== vecs[i].exp) begin
        errors++;
        $display("FAIL directed_%0d: got s/zvnc=%h required %h", i, r, vecs[i].exp);
      end
      checks++;
      if (lat != NCH) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d required %0d", i, lat, NCH);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corner[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF};
    logic [31:0] ra, rb;
    logic        rs, rg;
    res_t        r, e;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rs = 1'($urandom);
      rg = 1'($urandom);
      e  = model(ra, rb, rs, rg);
      run_op(ra, rb, rs, rg, r, lat);
      checks++;
      if (r !== e || lat != NCH) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h sub=%b sign=%b got %h lat %0d required %h lat %0d",
                 i, ra, rb, rs, rg, r, lat, e, NCH);
      end
    end
  endtask

  task automatic test_hold();
    res_t e, r;
    int   k;
    e = model(32'h00001234, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    a = 32'h00001234; b = 32'h00000001; sub = 1'b0; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
      @(posedge clk); #1;
      r = observed();
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || r !== e) begin
        errors++;
        $display("FAIL hold_%0d: valid/ready/busy=%b s/zvnc=%h required 101 %h",
                 i, {out_valid, in_ready, busy}, r, e);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL hold_release: valid/ready/busy=%b required 010", {out_valid, in_ready, busy});
    end
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL hold_keep: s/zvnc=%h required %h", observed(), e);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    int   lat;
    @(negedge clk);
    a = 32'h0F0F0F0F; b = 32'h01010101; sub = 1'b0; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || observed() !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid/ready/busy=%b s/zvnc=%h required 010 0",
               {out_valid, in_ready, busy}, observed());
    end
    // in_valid while reset is held must not capture anything.
    in_valid = 1'b1; a = 32'h5; b = 32'h5;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_no_capture: busy/ready=%b required 01", {busy, in_ready});
    end
    run_op(32'h1, 32'h1, 1'b0, 1'b0, r, lat);
    checks++;
    if (r.s !== 32'h2 || lat != NCH) begin
      errors++;
      $display("FAIL reset_recover: s=%h lat=%0d required 00000002 lat %0d", r.s, lat, NCH);
    end
  endtask

  task automatic test_back_to_back();
    res_t exp_q[$];
    res_t e;
    logic [31:0] ra, rb;
    logic rs, rg;
    int last_acc = -1;
    int cyc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (cyc = 0; cyc < 46; cyc++) begin
      @(negedge clk);
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rg = 1'($urandom);
      a = ra; b = rb; sub = rs; sign = rg;
      if (in_ready === 1'b1) begin
        exp_q.push_back(model(ra, rb, rs, rg));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != NCH + 2) begin
            errors++;
            $display("FAIL b2b_interval: got %0d required %0d", cyc - last_acc, NCH + 2);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL b2b_result: got %h required %h", observed(), e);
        end
      end
    end
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL b2b_drain: got %h required %h", observed(), e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_outstanding: %0d results missing, required 0", exp_q.size());
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_single_chunk();
    logic [7:0] va[2] = '{8'h7F, 8'h00};
    logic [7:0] vb[2] = '{8'h01, 8'h01};
    logic       vs[2] = '{1'b0, 1'b1};
    logic       vg[2] = '{1'b1, 1'b0};
    logic [11:0] ve[2] = '{{8'h80, 4'b0100}, {8'hFF, 4'b0100}};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; sub8 = vs[i]; sign8 = vg[i]; in_valid8 = 1'b1;
      @(posedge clk); #1; in_valid8 = 1'b0; a8 = 8'h55; b8 = 8'hAA;
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if ({s8, z8, v8, n8, c8} !== ve[i] || lat != 1) begin
        errors++;
        $display("FAIL single_chunk_%0d: s/zvnc=%h lat=%0d required %h lat 1",
                 i, {s8, z8, v8, n8, c8}, lat, ve[i]);
      end
      @(negedge clk); out_ready8 = 1'b1;
      @(posedge clk); #1; out_ready8 = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; sign = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; sign8 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_single_chunk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
